// File: rtl/uart_pkg.sv
// Shared definitions for the UART hex sender: frame states and ASCII constants.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SEND_HEX = 3'd1,
        SEND_CR  = 3'd2,
        SEND_LF  = 3'd3,
        DONE     = 3'd4
    } state_e;

    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;
    localparam logic [7:0] ASCII_0  = 8'h30;
    localparam logic [7:0] ASCII_A  = 8'h41;

endpackage

// File: rtl/nibble_to_ascii.sv
// Combinational conversion of one nibble to its uppercase ASCII hex character.
module nibble_to_ascii (
    input  logic [3:0] nibble,
    output logic [7:0] ascii
);
    import uart_pkg::*;

    logic [7:0] nibble_ext_s;

    assign nibble_ext_s = {4'h0, nibble};
    assign ascii = (nibble < 4'd10) ? (ASCII_0 + nibble_ext_s)
                                    : (ASCII_A + nibble_ext_s - 8'd10);

endmodule

// File: rtl/uart_hex_sender.sv
// Prints a DATA_W-bit value as uppercase hex on a UART write port, optionally
// followed by CR LF; bytes advance only while the UART FIFO is not full.
module uart_hex_sender #(
    parameter int DATA_W = 16,
    parameter int EOL_EN = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] din,
    input  logic              tx_full,
    output logic              wr_uart,
    output logic [7:0]        w_data,
    output logic              busy,
    output logic              done
);
    import uart_pkg::*;

    localparam int CNT_W = $clog2(DATA_W / 4) + 1;
    localparam logic [CNT_W-1:0] LAST_NIB = CNT_W'(DATA_W / 4 - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_e            state_r, state_next_s;
    logic [DATA_W-1:0] shift_r, shift_next_s;
    logic [CNT_W-1:0]  cnt_r, cnt_next_s;
    logic              wr_s;
    logic [7:0]        data_s;
    logic [7:0]        hex_char_s;

    nibble_to_ascii u_nibble_to_ascii (
        .nibble (shift_r[DATA_W-1 -: 4]),
        .ascii  (hex_char_s)
    );

    // State, shift register and nibble counter
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
            shift_r <= '0;
            cnt_r   <= '0;
        end else begin
            state_r <= state_next_s;
            shift_r <= shift_next_s;
            cnt_r   <= cnt_next_s;
        end
    end

    // Next-state logic and write-port drive; nothing moves while tx_full is set
    always_comb begin
        state_next_s = state_r;
        shift_next_s = shift_r;
        cnt_next_s   = cnt_r;
        wr_s         = 1'b0;
        data_s       = 8'h00;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_next_s = SEND_HEX;
                    shift_next_s = din;
                    cnt_next_s   = '0;
                end else begin
                    state_next_s = IDLE;
                end
            end
            SEND_HEX: begin
                data_s = hex_char_s;
                if (!tx_full) begin
                    wr_s         = 1'b1;
                    shift_next_s = shift_r << 4;
                    cnt_next_s   = cnt_r + CNT_ONE;
                    if (cnt_r == LAST_NIB) begin
                        state_next_s = (EOL_EN != 0) ? SEND_CR : DONE;
                    end else begin
                        state_next_s = SEND_HEX;
                    end
                end else begin
                    state_next_s = SEND_HEX;
                end
            end
            SEND_CR: begin
                data_s = ASCII_CR;
                if (!tx_full) begin
                    wr_s         = 1'b1;
                    state_next_s = SEND_LF;
                end else begin
                    state_next_s = SEND_CR;
                end
            end
            SEND_LF: begin
                data_s = ASCII_LF;
                if (!tx_full) begin
                    wr_s         = 1'b1;
                    state_next_s = DONE;
                end else begin
                    state_next_s = SEND_LF;
                end
            end
            DONE: begin
                state_next_s = IDLE;
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    assign wr_uart = wr_s;
    assign w_data  = data_s;
    assign busy    = (state_r != IDLE);
    assign done    = (state_r == DONE);

endmodule

// File: tb/tb_uart_hex_sender.sv
// Directed bench for uart_hex_sender: expected bytes are queued when a frame is
// started and popped by a write monitor; frame-level checks run inline.
module tb_uart_hex_sender;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [15:0] din = 16'h0000;
    logic        tx_full = 1'b0;
    logic        wr_uart;
    logic [7:0]  w_data;
    logic        busy;
    logic        done;

    logic        start0 = 1'b0;
    logic [15:0] din0 = 16'h0000;
    logic        wr_uart0;
    logic [7:0]  w_data0;
    logic        busy0;
    logic        done0;

    int vectors = 0;
    int miscompares = 0;
    int wr_total = 0;
    int wr0_total = 0;
    int done_total = 0;
    logic [7:0] exp_q[$];
    logic [7:0] exp0_q[$];

    always #5 clk = ~clk;

    uart_hex_sender #(.DATA_W(16), .EOL_EN(1)) dut (
        .clk(clk), .reset(reset), .start(start), .din(din), .tx_full(tx_full),
        .wr_uart(wr_uart), .w_data(w_data), .busy(busy), .done(done)
    );

    uart_hex_sender #(.DATA_W(16), .EOL_EN(0)) dut0 (
        .clk(clk), .reset(reset), .start(start0), .din(din0), .tx_full(tx_full),
        .wr_uart(wr_uart0), .w_data(w_data0), .busy(busy0), .done(done0)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every strobed byte must match the head of its queue
    always @(negedge clk) begin
        if (wr_uart === 1'b1) begin
            wr_total++;
            check("unexpected_write", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) check("byte", w_data, exp_q.pop_front());
        end
        if (wr_uart0 === 1'b1) begin
            wr0_total++;
            check("unexpected_write_eol0", exp0_q.size() != 0, 1);
            if (exp0_q.size() != 0) check("byte_eol0", w_data0, exp0_q.pop_front());
        end
        if (done === 1'b1) done_total++;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push_hex(input logic [15:0] v);
        for (int i = 3; i >= 0; i--) begin
            logic [3:0] n;
            n = v[i*4 +: 4];
            exp_q.push_back((n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n}));
        end
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
    endtask

    task automatic wait_done(input string tag, input bit eol0);
        bit seen = 1'b0;
        int n = 0;
        while (!seen && n < 40) begin
            @(negedge clk);
            if ((eol0 ? done0 : done) === 1'b1) seen = 1'b1;
            else n++;
        end
        check(tag, {31'd0, seen}, 1);
        tick;
    endtask

    initial begin
        int w0;
        int d0;
        tick;
        tick;
        reset = 1'b0;
        @(negedge clk);
        check("rst_wr_uart", wr_uart, 0);
        check("rst_w_data", w_data, 8'h00);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);

        // Scenario 1: back-to-back frame for 0x41A9
        push_hex(16'h41A9);
        start = 1'b1;
        din = 16'h41A9;
        tick;
        start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("b2b_wr_uart", wr_uart, 1);
            check("b2b_busy", busy, 1);
            tick;
        end
        @(negedge clk);
        check("s1_done", done, 1);
        check("s1_done_busy", busy, 1);
        check("s1_no_write_in_done", wr_uart, 0);
        check("s1_w_data_done", w_data, 8'h00);
        tick;
        @(negedge clk);
        check("s1_busy_low", busy, 0);
        check("s1_done_low", done, 0);
        check("s1_queue_empty", exp_q.size(), 0);
        tick;

        // Scenario 2: tx_full for 3 cycles after the 2nd byte
        w0 = wr_total;
        push_hex(16'h41A9);
        start = 1'b1;
        din = 16'h41A9;
        tick;
        start = 1'b0;
        tick;
        tick;
        tx_full = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("full_no_write", wr_uart, 0);
            check("full_hold_data", w_data, 8'h41);
            tick;
        end
        tx_full = 1'b0;
        wait_done("s2_done", 1'b0);
        check("s2_write_count", wr_total - w0, 6);
        check("s2_queue_empty", exp_q.size(), 0);

        // Scenario 3: start while busy is ignored
        push_hex(16'hBEEF);
        start = 1'b1;
        din = 16'hBEEF;
        tick;
        din = 16'h1234;
        tick;
        tick;
        start = 1'b0;
        wait_done("s3_done", 1'b0);
        check("s3_queue_empty", exp_q.size(), 0);
        @(negedge clk);
        check("s3_idle", busy, 0);
        tick;

        // Scenario 4: reset mid-frame, then a fresh frame
        d0 = done_total;
        exp_q.push_back(8'h34);
        exp_q.push_back(8'h31);
        start = 1'b1;
        din = 16'h41A9;
        tick;
        start = 1'b0;
        tick;
        tick;
        tx_full = 1'b1;
        reset = 1'b1;
        tick;
        reset = 1'b0;
        tx_full = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("abort_wr_uart", wr_uart, 0);
            check("abort_busy", busy, 0);
            tick;
        end
        check("abort_no_done", done_total - d0, 0);
        check("abort_queue_empty", exp_q.size(), 0);
        push_hex(16'h0000);
        start = 1'b1;
        din = 16'h0000;
        tick;
        start = 1'b0;
        wait_done("s4_done", 1'b0);
        check("s4_queue_empty", exp_q.size(), 0);

        // Scenario 5: EOL disabled, digits only
        w0 = wr0_total;
        for (int i = 0; i < 4; i++) exp0_q.push_back(8'h46);
        start0 = 1'b1;
        din0 = 16'hFFFF;
        tick;
        start0 = 1'b0;
        wait_done("s5_done", 1'b1);
        check("s5_write_count", wr0_total - w0, 4);
        check("s5_queue_empty", exp0_q.size(), 0);

        // Scenario 6: reset dominates start
        w0 = wr_total;
        start = 1'b1;
        din = 16'h1234;
        reset = 1'b1;
        tick;
        start = 1'b0;
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("rst_dom_busy", busy, 0);
            check("rst_dom_w_data", w_data, 8'h00);
            tick;
        end
        check("rst_dom_no_writes", wr_total - w0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/uart_hex_sender.md
UART_HEX_SENDER -- requirements
Module: uart_hex_sender

Interface
REQ-001 Parameters SHALL be, one per line:
  DATA_W  16  width of value to print; multiple of 4, range 4..32
  EOL_EN  1   1 = append CR LF after hex digits; 0 = digits only
REQ-002 Ports SHALL be, one per line (clock and reset first):
  clk      input   1       single clock; all logic on rising edge
  reset    input   1       synchronous, active-high reset
  start    input   1       request to print din; sampled only in IDLE
  din      input   DATA_W  value to print
  tx_full  input   1       UART transmit FIFO full flag
  wr_uart  output  1       UART transmit FIFO write strobe
  w_data   output  8       byte presented to UART write port
  busy     output  1       high from accepted start until end of DONE
  done     output  1       one-cycle pulse at frame completion
REQ-003 The block SHALL use one clock, clk; reset SHALL be synchronous and active-high.

Function
REQ-004 States SHALL be IDLE, SEND_HEX, SEND_CR, SEND_LF and DONE.
REQ-005 In IDLE, start=1 SHALL load din into a shift register and clear the nibble counter on that edge.
REQ-006 That same edge SHALL move IDLE to SEND_HEX, with busy=1 from the next cycle.
REQ-007 start SHALL be ignored in every state other than IDLE, with no effect on the frame in progress.
REQ-008 wr_uart SHALL be combinational: high exactly when the state is SEND_HEX, SEND_CR or SEND_LF and tx_full=0.
REQ-009 A byte SHALL advance only on an edge where wr_uart=1; with tx_full=1 the state, w_data and counter SHALL hold.
REQ-010 SEND_HEX SHALL emit DATA_W/4 nibbles, most significant first.
REQ-011 Each SEND_HEX write SHALL shift the register left 4 bits and increment the nibble counter.
REQ-012 Nibble encoding: 0-9 -> 0x30+n; 10-15 -> 0x41+(n-10), uppercase only.
REQ-013 After the last nibble: EOL_EN=1 -> SEND_CR (0x0D) then SEND_LF (0x0A) -> DONE; EOL_EN=0 -> DONE directly.
REQ-014 DONE SHALL last exactly one cycle with done=1 and busy=1, then return to IDLE with busy=0.
REQ-015 Latency: with tx_full=0 throughout, the first wr_uart SHALL occur in the cycle after start is accepted.
REQ-016 With tx_full=0 throughout, writes SHALL be back-to-back: DATA_W/4 + 2*EOL_EN consecutive cycles, then DONE.
REQ-017 w_data SHALL be 0x00 whenever not in a SEND state.
REQ-018 The nibble counter width SHALL be ceil(log2(DATA_W/4))+1 bits; it SHALL not wrap within a frame.
REQ-019 tx_full rising in the same cycle as the final write SHALL not affect DONE entry.

Reset
REQ-020 reset=1 on an edge SHALL force IDLE, clear the shift register and counter, and drive wr_uart=0, w_data=0x00, busy=0, done=0 from the next cycle.
REQ-021 reset SHALL dominate start on the same edge.
REQ-022 reset mid-frame SHALL abort with no further writes and no done pulse.

Structure
REQ-023 A shared package uart_pkg SHALL hold the state enum and the constants ASCII_CR=0x0D, ASCII_LF=0x0A, ASCII_0=0x30 and ASCII_A=0x41.
REQ-024 Nibble-to-ASCII conversion SHALL be a combinational sub-module nibble_to_ascii (4-bit in, 8-bit out).
REQ-025 wr_uart/w_data SHALL connect directly to the UART write port; tx_full SHALL come from the same UART.

Verification
REQ-026 The bench SHALL cover these directed scenarios:
  - Defaults, tx_full=0, start with din=0x41A9 -> wr_uart 6 consecutive cycles with w_data 0x34,0x31,0x41,0x39,0x0D,0x0A; done pulse next cycle; busy low after.
  - Same frame with tx_full=1 for 3 cycles after the 2nd byte -> no writes while full; byte order intact; no duplicates; done after 6 writes total.
  - start with din=0x1234 while busy from 0xBEEF -> ignored; output stays 0x42,0x45,0x45,0x46,0x0D,0x0A.
  - reset after the 2nd byte of 0x41A9 -> wr_uart=0 next cycle, busy=0, no done; next start with 0x0000 -> 0x30 x4, 0x0D, 0x0A.
  - EOL_EN=0, din=0xFFFF -> exactly four 0x46 writes, then done.
  - start and reset on the same edge -> stays IDLE, no writes.
